mio_bus_arbiter: RTL

Shares the single memory/IO bus between the multi-cycle CPU controller and a DMA requester. Each requester raises a request with address, write data and write-enable. The arbiter grants one requester at a time, drives the bus, counts memory wait states, and returns a one-cycle ready pulse with registered read data. The CPU side connects directly to the controller's CPU_MIO / MIO_ready handshake; the controller stalls in IF until `cpu_ready`.

---
 rtl/mio_pkg.sv | 14 +
 rtl/mio_bus_arbiter_if.sv | 15 +
 rtl/rr_arbiter2.sv | 15 +
 rtl/mio_bus_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared encodings for the CPU/DMA memory-bus arbiter.
package mio_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DMA  = 2'b10;
    localparam logic       LAST_CPU = 1'b0;
    localparam logic       LAST_DMA = 1'b1;
endpackage

// File: rtl/mio_bus_arbiter_if.sv
// Requester-side handshake bundle: one instance per bus master (CPU, DMA).
interface mio_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker; on a tie the requester that did not win last is chosen.
module rr_arbiter2
    import mio_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == LAST_DMA) ? OWN_CPU : OWN_DMA;
        end
    end
endmodule

// File: rtl/mio_bus_arbiter.sv
// Shares one memory/IO bus between CPU and DMA: grant, issue, wait states, ready pulse.
module mio_bus_arbiter
    import mio_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    mio_bus_arbiter_if.slave    cpu,
    mio_bus_arbiter_if.slave    dma,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          grant,
    output logic [1:0]          state_out
);
    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic               last_q, last_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]  dma_rdata_q, dma_rdata_d;
    logic [1:0]         pick;
    logic               capture;

    rr_arbiter2 u_rr (
        .req  ({dma.req, cpu.req}),
        .last (last_q),
        .gnt  (pick)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        capture     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick != 2'b00) begin
                    owner_d = pick;
                    we_d    = pick[0] ? cpu.we    : dma.we;
                    addr_d  = pick[0] ? cpu.addr  : dma.addr;
                    wdata_d = pick[0] ? cpu.wdata : dma.wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = CNT_W'(WAIT_CYCLES);
                if (WAIT_CYCLES > 0) begin
                    state_d = WAIT;
                end else begin
                    state_d = DONE;
                    capture = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = DONE;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                last_d  = (owner_q == OWN_DMA) ? LAST_DMA : LAST_CPU;
                owner_d = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Read data is taken on the edge that leaves the last bus-hold cycle.
        if (capture && !we_q) begin
            if (owner_q == OWN_CPU) begin
                cpu_rdata_d = mem_rdata;
            end else begin
                dma_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= 2'b00;
            last_q      <= LAST_DMA;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign mem_en    = (state_q == ISSUE) || (state_q == WAIT);
    assign mem_we    = (state_q == ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign grant     = owner_q;
    assign state_out = state_q;

    assign cpu.ready = (state_q == DONE) && (owner_q == OWN_CPU);
    assign dma.ready = (state_q == DONE) && (owner_q == OWN_DMA);
    assign cpu.rdata = cpu_rdata_q;
    assign dma.rdata = dma_rdata_q;
endmodule
